// File: rtl/jellyvl_stream_arbiter_rr_if.sv
// Bundle of parallel valid/ready stream lanes. The arbiter uses an N-lane
// bundle for its upstream side and a single-lane bundle for its merged output.
interface jellyvl_stream_arbiter_rr_if #(
    parameter int  LANES   = 1,
    parameter int  ID_BITS = 1,
    parameter type t_data  = logic [7:0]
);
    t_data              data [LANES];
    logic [LANES-1:0]   last;
    logic [LANES-1:0]   valid;
    logic [LANES-1:0]   ready;
    logic [ID_BITS-1:0] id;

    modport master (output data, output last, output valid, output id, input ready);
    modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/jellyvl_stream_arbiter_rr.sv
// Packet-aware round-robin arbiter merging N upstream streams onto one
// registered downstream stream without interleaving packets.
module jellyvl_stream_arbiter_rr #(
    parameter int    N         = 4,
    parameter type   t_data    = logic [7:0],
    parameter bit    USE_LAST  = 1'b1,
    parameter t_data INIT_DATA = 'x
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cke,
    jellyvl_stream_arbiter_rr_if.slave  s,
    jellyvl_stream_arbiter_rr_if.master m
);
    localparam int ID_BITS = (N > 1) ? $clog2(N) : 1;

    typedef logic [ID_BITS-1:0] id_t;
    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state_q, state_d;
    id_t          ptr_q, ptr_d;
    id_t          grant_q, grant_d;
    t_data        m_data_q, m_data_d;
    logic         m_last_q, m_last_d;
    logic         m_valid_q, m_valid_d;
    id_t          m_id_q, m_id_d;

    id_t          sel;
    int           idx;
    logic         found;
    logic         ir;
    logic         accept;
    logic         pkt_end;
    logic         load;
    logic [N-1:0] ready;

    assign ir     = cke & ~rst & (~m_valid_q | m.ready[0]);
    assign load   = cke & (~m_valid_q | m.ready[0]);
    assign accept = found & ir;

    // While a packet is open only its owner may proceed; otherwise scan from ptr
    // downwards in priority so the lowest rotated offset with valid wins.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (state_q == BUSY) begin
            sel   = grant_q;
            found = s.valid[grant_q];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (s.valid[idx]) begin
                    sel   = id_t'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (found) begin
            ready[sel] = ir;
        end
    end

    assign s.ready = ready;
    assign pkt_end = ~USE_LAST | s.last[sel];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        m_id_d    = m_id_q;

        if (accept) begin
            if (pkt_end) begin
                state_d = IDLE;
                ptr_d   = (int'(sel) == N - 1) ? '0 : sel + id_t'(1);
            end else begin
                state_d = BUSY;
                grant_d = sel;
            end
        end

        // An empty slot is written as a bubble so a stale beat is never replayed.
        if (load) begin
            m_valid_d = accept;
            if (accept) begin
                m_data_d = s.data[sel];
                m_last_d = s.last[sel];
                m_id_d   = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            m_data_q  <= INIT_DATA;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_id_q    <= '0;
        end else if (cke) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            m_id_q    <= m_id_d;
        end
    end

    assign m.data[0] = m_data_q;
    assign m.last    = m_last_q;
    assign m.valid   = m_valid_q;
    assign m.id      = m_id_q;

endmodule

// File: tb/tb_jellyvl_stream_arbiter_rr.sv
// Self-checking bench: directed scenarios on a 4-way packet arbiter, then a
// randomized run on 3-way arbiters (packet-locked and per-beat) against a model.
`timescale 1ns/1ps
module tb_jellyvl_stream_arbiter_rr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // 4-way packet-locked arbiter for the directed scenarios
    jellyvl_stream_arbiter_rr_if #(.LANES(4), .ID_BITS(2), .t_data(logic [7:0])) up4 ();
    jellyvl_stream_arbiter_rr_if #(.LANES(1), .ID_BITS(2), .t_data(logic [7:0])) dn4 ();
    logic [3:0] v4, l4;
    logic [7:0] d4 [4];
    logic       mr4, cke4;

    assign up4.valid = v4;
    assign up4.last  = l4;
    assign up4.id    = '0;
    assign dn4.ready = mr4;
    for (genvar i = 0; i < 4; i++) begin : g_d4
        assign up4.data[i] = d4[i];
    end

    jellyvl_stream_arbiter_rr #(.N(4), .t_data(logic [7:0]), .USE_LAST(1'b1), .INIT_DATA(8'h00)) dut4 (
        .clk(clk), .rst(rst), .cke(cke4), .s(up4), .m(dn4));

    // Two 3-way arbiters for the random run: index 0 locks on packets, index 1 does not
    jellyvl_stream_arbiter_rr_if #(.LANES(3), .ID_BITS(2), .t_data(logic [7:0])) upA ();
    jellyvl_stream_arbiter_rr_if #(.LANES(1), .ID_BITS(2), .t_data(logic [7:0])) dnA ();
    jellyvl_stream_arbiter_rr_if #(.LANES(3), .ID_BITS(2), .t_data(logic [7:0])) upB ();
    jellyvl_stream_arbiter_rr_if #(.LANES(1), .ID_BITS(2), .t_data(logic [7:0])) dnB ();

    logic [2:0] rv [2];
    logic [2:0] rl [2];
    logic [7:0] rd [2][3];
    logic       rmr [2];
    logic       rcke [2];
    logic [2:0] sr [2];
    logic [7:0] md [2];
    logic       ml [2];
    logic       mv [2];
    logic [1:0] mid [2];

    assign upA.valid = rv[0];
    assign upA.last  = rl[0];
    assign upA.id    = '0;
    assign dnA.ready = rmr[0];
    assign upB.valid = rv[1];
    assign upB.last  = rl[1];
    assign upB.id    = '0;
    assign dnB.ready = rmr[1];
    for (genvar i = 0; i < 3; i++) begin : g_dr
        assign upA.data[i] = rd[0][i];
        assign upB.data[i] = rd[1][i];
    end
    assign sr[0]  = upA.ready;
    assign md[0]  = dnA.data[0];
    assign ml[0]  = dnA.last[0];
    assign mv[0]  = dnA.valid[0];
    assign mid[0] = dnA.id;
    assign sr[1]  = upB.ready;
    assign md[1]  = dnB.data[0];
    assign ml[1]  = dnB.last[0];
    assign mv[1]  = dnB.valid[0];
    assign mid[1] = dnB.id;

    jellyvl_stream_arbiter_rr #(.N(3), .t_data(logic [7:0]), .USE_LAST(1'b1), .INIT_DATA(8'h00)) dutA (
        .clk(clk), .rst(rst), .cke(rcke[0]), .s(upA), .m(dnA));
    jellyvl_stream_arbiter_rr #(.N(3), .t_data(logic [7:0]), .USE_LAST(1'b0), .INIT_DATA(8'h00)) dutB (
        .clk(clk), .rst(rst), .cke(rcke[1]), .s(upB), .m(dnB));

    // Reference model state for the random run
    int         lock [2];
    int         ptr [2];
    logic       eV [2];
    logic       eL [2];
    logic [7:0] eD [2];
    int         eId [2];
    int         seq [2][3];
    int         outSeq [2][3];
    int         waitPk [2][3];
    logic       openPkt [2];
    int         openId [2];
    int         gS [2];
    bit         hasS [2];
    bit         irS [2];

    task automatic test_reset();
        rst  = 1'b1;
        v4   = '1;
        l4   = '1;
        mr4  = 1'b1;
        cke4 = 1'b1;
        for (int i = 0; i < 4; i++) d4[i] = 8'h00;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rl[d] = '0; rmr[d] = 1'b1; rcke[d] = 1'b1;
            for (int i = 0; i < 3; i++) rd[d][i] = 8'h00;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (up4.ready !== 4'b0000) begin
                errors++; $display("[TB] FAIL reset_ready cycle %0d got %b exp 0000", c, up4.ready);
            end
            checks++;
            if (dn4.valid[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_valid cycle %0d got %b exp 0", c, dn4.valid[0]);
            end
            checks++;
            if (dn4.id !== 2'd0) begin
                errors++; $display("[TB] FAIL reset_id cycle %0d got %0d exp 0", c, dn4.id);
            end
        end
    endtask

    task automatic test_rr_single();
        logic [3:0] expR;
        for (int i = 0; i < 4; i++) d4[i] = 8'(8'h10 + i);
        v4 = '1; l4 = '1; mr4 = 1'b1; cke4 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (dn4.valid[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL rr_first_valid got %b exp 0", dn4.valid[0]);
        end
        for (int k = 0; k < 8; k++) begin
            expR = 4'(1 << (k % 4));
            checks++;
            if (up4.ready !== expR) begin
                errors++; $display("[TB] FAIL rr_ready beat %0d got %b exp %b", k, up4.ready, expR);
            end
            @(posedge clk); #1;
            checks++;
            if (dn4.valid[0] !== 1'b1 || dn4.id !== 2'(k % 4) || dn4.data[0] !== 8'(8'h10 + k % 4)) begin
                errors++;
                $display("[TB] FAIL rr_out beat %0d got v=%b id=%0d data=%h exp v=1 id=%0d data=%h",
                         k, dn4.valid[0], dn4.id, dn4.data[0], k % 4, 8'(8'h10 + k % 4));
            end
        end
        v4 = '0;
    endtask

    task automatic test_packet_lock();
        logic [3:0] tv    [4] = '{4'b0001, 4'b0011, 4'b0011, 4'b0010};
        logic [3:0] tl    [4] = '{4'b0000, 4'b0010, 4'b0011, 4'b0010};
        logic [7:0] td0   [4] = '{8'h20, 8'h21, 8'h22, 8'h22};
        logic [3:0] expR  [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [1:0] expId [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        logic [7:0] expD  [4] = '{8'h20, 8'h21, 8'h22, 8'h30};
        logic       expL  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        d4[1] = 8'h30;
        for (int c = 0; c < 4; c++) begin
            v4 = tv[c]; l4 = tl[c]; d4[0] = td0[c];
            #1;
            checks++;
            if (up4.ready !== expR[c]) begin
                errors++; $display("[TB] FAIL lock_ready cycle %0d got %b exp %b", c, up4.ready, expR[c]);
            end
            @(posedge clk); #1;
            checks++;
            if (dn4.valid[0] !== 1'b1 || dn4.id !== expId[c] || dn4.data[0] !== expD[c] || dn4.last[0] !== expL[c]) begin
                errors++;
                $display("[TB] FAIL lock_out cycle %0d got v=%b id=%0d data=%h last=%b exp v=1 id=%0d data=%h last=%b",
                         c, dn4.valid[0], dn4.id, dn4.data[0], dn4.last[0], expId[c], expD[c], expL[c]);
            end
        end
        v4 = '0;
    endtask

    task automatic test_backpressure();
        v4 = 4'b1100; l4 = 4'b1100; d4[2] = 8'h42; d4[3] = 8'h43; mr4 = 1'b1;
        #1;
        checks++;
        if (up4.ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL bp_first_ready got %b exp 0100", up4.ready);
        end
        @(posedge clk); #1;
        v4 = 4'b1000; mr4 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++;
            if (up4.ready !== 4'b0000) begin
                errors++; $display("[TB] FAIL bp_stall_ready cycle %0d got %b exp 0000", j, up4.ready);
            end
            checks++;
            if (dn4.valid[0] !== 1'b1 || dn4.id !== 2'd2 || dn4.data[0] !== 8'h42 || dn4.last[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d got v=%b id=%0d data=%h last=%b exp v=1 id=2 data=42 last=1",
                         j, dn4.valid[0], dn4.id, dn4.data[0], dn4.last[0]);
            end
            @(posedge clk); #1;
        end
        mr4 = 1'b1;
        #1;
        checks++;
        if (up4.ready !== 4'b1000) begin
            errors++; $display("[TB] FAIL bp_resume_ready got %b exp 1000", up4.ready);
        end
        @(posedge clk); #1;
        checks++;
        if (dn4.valid[0] !== 1'b1 || dn4.id !== 2'd3 || dn4.data[0] !== 8'h43) begin
            errors++;
            $display("[TB] FAIL bp_resume_out got v=%b id=%0d data=%h exp v=1 id=3 data=43",
                     dn4.valid[0], dn4.id, dn4.data[0]);
        end
        v4 = '0;
    endtask

    task automatic test_cke_wrap();
        v4 = 4'b1000; l4 = 4'b1111; d4[3] = 8'h53;
        #1;
        checks++;
        if (up4.ready !== 4'b1000) begin
            errors++; $display("[TB] FAIL cke_grant3_ready got %b exp 1000", up4.ready);
        end
        @(posedge clk); #1;
        cke4 = 1'b0;
        v4 = 4'b1111;
        for (int i = 0; i < 4; i++) d4[i] = 8'(8'h60 + i);
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (up4.ready !== 4'b0000) begin
                errors++; $display("[TB] FAIL cke_ready cycle %0d got %b exp 0000", j, up4.ready);
            end
            checks++;
            if (dn4.valid[0] !== 1'b1 || dn4.id !== 2'd3 || dn4.data[0] !== 8'h53) begin
                errors++;
                $display("[TB] FAIL cke_hold cycle %0d got v=%b id=%0d data=%h exp v=1 id=3 data=53",
                         j, dn4.valid[0], dn4.id, dn4.data[0]);
            end
            @(posedge clk); #1;
        end
        cke4 = 1'b1;
        #1;
        checks++;
        if (up4.ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL wrap_ready got %b exp 0001", up4.ready);
        end
        @(posedge clk); #1;
        checks++;
        if (dn4.valid[0] !== 1'b1 || dn4.id !== 2'd0 || dn4.data[0] !== 8'h60) begin
            errors++;
            $display("[TB] FAIL wrap_out got v=%b id=%0d data=%h exp v=1 id=0 data=60",
                     dn4.valid[0], dn4.id, dn4.data[0]);
        end
        v4 = '0;
    endtask

    task automatic test_random(input int cycles);
        logic [2:0] expR;
        bit         acc;
        bit         pktEnd;
        int         g;
        int         j;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rl[d] = '0; rmr[d] = 1'b1; rcke[d] = 1'b1;
            lock[d] = -1; ptr[d] = 0; eV[d] = 1'b0; eL[d] = 1'b0; eD[d] = 8'h00; eId[d] = 0;
            openPkt[d] = 1'b0; openId[d] = 0;
            for (int i = 0; i < 3; i++) begin
                seq[d][i] = 0; outSeq[d][i] = 0; waitPk[d][i] = 0;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!rv[d][i] && $urandom_range(9, 0) < 6) begin
                        rv[d][i] = 1'b1;
                        rl[d][i] = ($urandom_range(2, 0) == 0);
                        rd[d][i] = 8'((i << 6) | (seq[d][i] % 64));
                    end
                end
                rmr[d]  = ($urandom_range(9, 0) < 7);
                rcke[d] = ($urandom_range(9, 0) < 9);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                irS[d] = rcke[d] && (!eV[d] || rmr[d]);
                hasS[d] = 1'b0;
                gS[d] = 0;
                if (lock[d] >= 0) begin
                    gS[d] = lock[d];
                    hasS[d] = rv[d][lock[d]];
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        j = (ptr[d] + k) % 3;
                        if (!hasS[d] && rv[d][j]) begin
                            gS[d] = j; hasS[d] = 1'b1;
                        end
                    end
                end
                expR = (hasS[d] && irS[d]) ? 3'(1 << gS[d]) : 3'b000;
                checks++;
                if (sr[d] !== expR) begin
                    errors++; $display("[TB] FAIL rand_ready dut%0d cycle %0d got %b exp %b", d, c, sr[d], expR);
                end
                checks++;
                if (mv[d] !== eV[d]) begin
                    errors++; $display("[TB] FAIL rand_valid dut%0d cycle %0d got %b exp %b", d, c, mv[d], eV[d]);
                end
                if (eV[d]) begin
                    checks++;
                    if (mid[d] !== 2'(eId[d]) || md[d] !== eD[d] || ml[d] !== eL[d]) begin
                        errors++;
                        $display("[TB] FAIL rand_out dut%0d cycle %0d got id=%0d data=%h last=%b exp id=%0d data=%h last=%b",
                                 d, c, mid[d], md[d], ml[d], eId[d], eD[d], eL[d]);
                    end
                end
                // Per-ID order and packet contiguity, judged on beats leaving the DUT
                if (mv[d] === 1'b1 && rmr[d] && rcke[d]) begin
                    checks++;
                    if (md[d][7:6] !== mid[d] || int'(md[d][5:0]) != outSeq[d][mid[d]] % 64) begin
                        errors++;
                        $display("[TB] FAIL rand_order dut%0d cycle %0d id=%0d data=%h exp seq %0d",
                                 d, c, mid[d], md[d], outSeq[d][mid[d]] % 64);
                    end
                    outSeq[d][mid[d]]++;
                    if (d == 0) begin
                        checks++;
                        if (openPkt[d] && int'(mid[d]) != openId[d]) begin
                            errors++;
                            $display("[TB] FAIL rand_interleave cycle %0d got id=%0d exp id=%0d", c, mid[d], openId[d]);
                        end
                        openPkt[d] = !ml[d];
                        openId[d] = int'(mid[d]);
                    end
                end
            end
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                g = gS[d];
                acc = hasS[d] && irS[d];
                if (irS[d]) begin
                    eV[d] = acc;
                    if (acc) begin
                        eD[d] = rd[d][g]; eL[d] = rl[d][g]; eId[d] = g;
                    end
                end
                if (acc) begin
                    pktEnd = (d == 1) || rl[d][g];
                    waitPk[d][g] = 0;
                    if (pktEnd) begin
                        lock[d] = -1;
                        ptr[d] = (g + 1) % 3;
                        for (int i = 0; i < 3; i++) begin
                            if (i != g && rv[d][i]) begin
                                waitPk[d][i]++;
                                checks++;
                                if (waitPk[d][i] > 2) begin
                                    errors++;
                                    $display("[TB] FAIL rand_fair dut%0d cycle %0d req %0d waited %0d packets exp <= 2",
                                             d, c, i, waitPk[d][i]);
                                end
                            end
                        end
                    end else begin
                        lock[d] = g;
                    end
                    rv[d][g] = 1'b0;
                    seq[d][g]++;
                end
            end
        end
        for (int d = 0; d < 2; d++) rv[d] = '0;
    endtask

    initial begin
        $display("[TB] starting");
        test_reset();
        test_rr_single();
        test_packet_lock();
        test_backpressure();
        test_cke_wrap();
        test_random(10000);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
